// File: rtl/dds_tune_ctrl.sv
// Tuning controller for the DDS core: turns debounced key pulses into frequency and
// phase control words, with a manual stepping mode and an automatic triangle sweep.
module dds_tune_ctrl #(
  parameter int unsigned FW_INIT   = 1074,
  parameter int unsigned F_MIN     = 430,
  parameter int unsigned F_MAX     = 107374,
  parameter int unsigned F_STEP    = 2,
  parameter int unsigned P_STEP    = 2,
  parameter int unsigned SWEEP_DIV = 500000
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        key_f_pls,
  input  logic        key_p_pls,
  input  logic        key_m_pls,
  output logic [29:0] fc_word,
  output logic [29:0] pc_word,
  output logic        upd,
  output logic        sweep_on,
  output logic        led0
);

  localparam int unsigned DIV_W = $clog2(SWEEP_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SWEEP_DIV - 1);

  localparam logic [30:0] F_MIN_31  = 31'(F_MIN);
  localparam logic [30:0] F_MAX_31  = 31'(F_MAX);
  localparam logic [30:0] F_STEP_31 = 31'(F_STEP);
  localparam logic [29:0] F_MIN_30  = 30'(F_MIN);
  localparam logic [29:0] F_MAX_30  = 30'(F_MAX);
  localparam logic [29:0] F_STEP_30 = 30'(F_STEP);
  localparam logic [29:0] P_STEP_30 = 30'(P_STEP);

  typedef enum logic [1:0] {
    MANUAL   = 2'd0,
    SWEEP_UP = 2'd1,
    SWEEP_DN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [29:0]      fc_q, fc_d;
  logic [29:0]      pc_q, pc_d;
  logic             upd_q, upd_d;
  logic             led_q, led_d;

  logic [30:0] fc_ext;
  logic [30:0] fc_up;
  logic        tick;
  logic        fc_chg;
  logic        pc_chg;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    fc_d    = fc_q;
    pc_d    = pc_q;
    led_d   = led_q;
    fc_chg  = 1'b0;
    pc_chg  = 1'b0;

    // One spare bit so the step past F_MAX is visible before it is committed.
    fc_ext = {1'b0, fc_q};
    fc_up  = fc_ext + F_STEP_31;
    tick   = (div_q == DIV_LAST);

    unique case (state_q)
      MANUAL: begin
        if (key_m_pls) begin
          state_d = SWEEP_UP;
          div_d   = '0;
        end else if (key_f_pls) begin
          fc_chg = 1'b1;
          fc_d   = (fc_up > F_MAX_31) ? F_MIN_30 : fc_up[29:0];
        end
      end

      SWEEP_UP, SWEEP_DN: begin
        if (key_m_pls) begin
          // Leaving the sweep discards a tick landing in the same cycle.
          state_d = MANUAL;
          div_d   = '0;
        end else begin
          div_d = tick ? '0 : div_q + DIV_W'(1);
          if (tick) begin
            fc_chg = 1'b1;
            if (state_q == SWEEP_UP) begin
              if (fc_up >= F_MAX_31) begin
                fc_d    = F_MAX_30;
                state_d = SWEEP_DN;
              end else begin
                fc_d = fc_up[29:0];
              end
            end else begin
              // Compare against F_MIN+F_STEP so the subtraction can never underflow.
              if (fc_ext <= F_MIN_31 + F_STEP_31) begin
                fc_d    = F_MIN_30;
                state_d = SWEEP_UP;
              end else begin
                fc_d = fc_q - F_STEP_30;
              end
            end
          end
        end
      end

      default: begin
        state_d = MANUAL;
        div_d   = '0;
      end
    endcase

    if (key_p_pls) begin
      pc_chg = 1'b1;
      pc_d   = pc_q + P_STEP_30;
      led_d  = ~led_q;
    end

    upd_d = fc_chg | pc_chg;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MANUAL;
      div_q   <= '0;
      fc_q    <= 30'(FW_INIT);
      pc_q    <= '0;
      upd_q   <= 1'b0;
      led_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      fc_q    <= fc_d;
      pc_q    <= pc_d;
      upd_q   <= upd_d;
      led_q   <= led_d;
    end
  end

  assign fc_word  = fc_q;
  assign pc_word  = pc_q;
  assign upd      = upd_q;
  assign sweep_on = (state_q != MANUAL);
  assign led0     = led_q;

endmodule

// File: tb/tb_dds_tune_ctrl.sv
// Scoreboard bench for dds_tune_ctrl: two instances (long-range manual/sweep and a
// narrow sweep band with a large phase step for wrap), each with its own monitor.
module tb_dds_tune_ctrl;

  typedef struct {
    int          cyc;
    logic [29:0] fc;
    logic [29:0] pc;
    logic        led;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic        kf_a = 1'b0, kp_a = 1'b0, km_a = 1'b0;
  logic [29:0] fc_a, pc_a;
  logic        upd_a, sweep_a, led_a;

  logic        kf_b = 1'b0, kp_b = 1'b0, km_b = 1'b0;
  logic [29:0] fc_b, pc_b;
  logic        upd_b, sweep_b, led_b;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t e_a, e_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dds_tune_ctrl #(
    .FW_INIT(1074), .F_MIN(430), .F_MAX(1080), .F_STEP(2), .P_STEP(2), .SWEEP_DIV(4)
  ) u_dut_a (
    .sclk(clk), .rst_n(rst_n),
    .key_f_pls(kf_a), .key_p_pls(kp_a), .key_m_pls(km_a),
    .fc_word(fc_a), .pc_word(pc_a), .upd(upd_a), .sweep_on(sweep_a), .led0(led_a)
  );

  dds_tune_ctrl #(
    .FW_INIT(430), .F_MIN(430), .F_MAX(436), .F_STEP(2), .P_STEP(536870913), .SWEEP_DIV(4)
  ) u_dut_b (
    .sclk(clk), .rst_n(rst_n),
    .key_f_pls(kf_b), .key_p_pls(kp_b), .key_m_pls(km_b),
    .fc_word(fc_b), .pc_word(pc_b), .upd(upd_b), .sweep_on(sweep_b), .led0(led_b)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input longint act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: observed %0d at cycle %0d", name, act, cyc);
  endtask

  task automatic push_a(input int c, input int fc, input int pc, input bit led);
    exp_t e;
    e.cyc = c; e.fc = 30'(fc); e.pc = 30'(pc); e.led = led;
    exp_a.push_back(e);
  endtask

  task automatic push_b(input int c, input int fc, input int pc, input bit led);
    exp_t e;
    e.cyc = c; e.fc = 30'(fc); e.pc = 30'(pc); e.led = led;
    exp_b.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_a(input bit f, input bit p, input bit m);
    kf_a = f; kp_a = p; km_a = m;
    @(negedge clk);
    kf_a = 1'b0; kp_a = 1'b0; km_a = 1'b0;
  endtask

  task automatic pulse_b(input bit f, input bit p, input bit m);
    kf_b = f; kp_b = p; km_b = m;
    @(negedge clk);
    kf_b = 1'b0; kp_b = 1'b0; km_b = 1'b0;
  endtask

  // Monitors: every upd must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (upd_a) begin
        if (exp_a.size() == 0) flag("a_spurious_upd", fc_a);
        else begin
          e_a = exp_a.pop_front();
          check("a_upd_cycle", cyc, e_a.cyc);
          check("a_fc", fc_a, e_a.fc);
          check("a_pc", pc_a, e_a.pc);
          check("a_led", led_a, e_a.led);
        end
      end else if (exp_a.size() != 0 && exp_a[0].cyc <= cyc) begin
        e_a = exp_a.pop_front();
        flag("a_missing_upd", e_a.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (upd_b) begin
        if (exp_b.size() == 0) flag("b_spurious_upd", fc_b);
        else begin
          e_b = exp_b.pop_front();
          check("b_upd_cycle", cyc, e_b.cyc);
          check("b_fc", fc_b, e_b.fc);
          check("b_pc", pc_b, e_b.pc);
          check("b_led", led_b, e_b.led);
        end
      end else if (exp_b.size() != 0 && exp_b[0].cyc <= cyc) begin
        e_b = exp_b.pop_front();
        flag("b_missing_upd", e_b.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int sweep_exp[7];
    sweep_exp = '{432, 434, 436, 434, 432, 430, 432};

    #1 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    check("a_reset_fc", fc_a, 1074);
    check("a_reset_pc", pc_a, 0);
    check("a_reset_upd", upd_a, 0);
    check("a_reset_sweep", sweep_a, 0);
    check("a_reset_led", led_a, 1);
    check("b_reset_fc", fc_b, 430);

    // Three frequency presses spaced five cycles apart.
    for (int i = 0; i < 3; i++) begin
      push_a(cyc + 1, 1076 + 2 * i, 0, 1);
      pulse_a(1, 0, 0);
      idle(4);
    end

    // 1080 + 2 exceeds F_MAX: wraps to F_MIN.
    push_a(cyc + 1, 430, 0, 1);
    pulse_a(1, 0, 0);
    idle(2);

    // Two phase presses toggle led0 down then back up.
    push_a(cyc + 1, 430, 2, 0);
    pulse_a(0, 1, 0);
    idle(1);
    push_a(cyc + 1, 430, 4, 1);
    pulse_a(0, 1, 0);
    idle(2);

    // Frequency and phase together: one upd carrying both.
    push_a(cyc + 1, 432, 6, 0);
    pulse_a(1, 1, 0);
    idle(2);

    // Mode with frequency in MANUAL: mode wins, no upd, fc held.
    k = cyc;
    pulse_a(1, 0, 1);
    check("a_sweep_on_enter", sweep_a, 1);
    check("a_fc_on_enter", fc_a, 432);
    push_a(k + 5, 434, 6, 0);
    idle(1);
    pulse_a(1, 0, 0);                 // ignored during sweep
    push_a(k + 9, 436, 8, 1);
    idle(5);
    pulse_a(0, 1, 0);                 // lands on the tick at k+9
    push_a(k + 13, 438, 8, 1);
    idle(4);

    // Asynchronous reset while upd is high mid-sweep.
    #1 rst_n = 1'b0;
    #1;
    check("a_async_fc", fc_a, 1074);
    check("a_async_pc", pc_a, 0);
    check("a_async_upd", upd_a, 0);
    check("a_async_sweep", sweep_a, 0);
    check("a_async_led", led_a, 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("a_post_reset_sweep", sweep_a, 0);
    check("a_post_reset_fc", fc_a, 1074);
    push_a(cyc + 1, 1076, 0, 1);
    pulse_a(1, 0, 0);
    idle(2);

    // Narrow-band triangle sweep on instance B.
    k = cyc;
    pulse_b(0, 0, 1);
    check("b_sweep_on_enter", sweep_b, 1);
    for (int j = 0; j < 7; j++) push_b(k + 5 + 4 * j, sweep_exp[j], 0, 1);
    idle(5);
    pulse_b(1, 0, 0);                 // k+7, not a tick: ignored
    check("b_sweep_on_mid", sweep_b, 1);
    idle(25);
    pulse_b(0, 0, 1);                 // exit sampled on the k+33 tick: tick dropped
    check("b_sweep_off", sweep_b, 0);
    check("b_fc_hold_exit", fc_b, 432);
    idle(6);
    check("b_fc_hold_manual", fc_b, 432);

    // Phase wraps naturally at 2^30.
    push_b(cyc + 1, 432, 536870913, 0);
    pulse_b(0, 1, 0);
    idle(1);
    push_b(cyc + 1, 432, 2, 1);
    pulse_b(0, 1, 0);
    idle(3);

    check("a_queue_drained", exp_a.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_tune_ctrl.md
Name: dds_tune_ctrl

Overview:
Synchronous tuning controller for the DDS datapath. It converts single-cycle debounced key pulses into frequency and phase control words (30-bit phase accumulator, 2^30 full scale). It provides a MANUAL stepping mode and an automatic triangle SWEEP mode. It drives fc_word/pc_word into the DDS core with a one-cycle update strobe, replacing key-edge-clocked registers with logic that runs only on sclk.

Parameters:
FW_INIT, 1074, fc_word value after reset
F_MIN, 430, lowest legal frequency word
F_MAX, 107374, highest legal frequency word
F_STEP, 2, frequency increment per key press or sweep tick
P_STEP, 2, phase increment per key press
SWEEP_DIV, 500000, sclk cycles between sweep ticks (≥2)

Ports:
sclk  in  1  system clock (50 MHz)
rst_n  in  1  reset
key_f_pls  in  1  debounced frequency-key press, 1-cycle pulse
key_p_pls  in  1  debounced phase-key press, 1-cycle pulse
key_m_pls  in  1  debounced mode-key press, 1-cycle pulse
fc_word  out  30  frequency control word to DDS
pc_word  out  30  phase control word to DDS
upd  out  1  1-cycle strobe: fc_word/pc_word changed this cycle
sweep_on  out  1  1 while in SWEEP_UP/SWEEP_DN
led0  out  1  toggles on each accepted phase press

Behaviour:
- Reset: rst_n, asynchronous, active-low. fc_word=FW_INIT, pc_word=0, upd=0, sweep_on=0, led0=1, state=MANUAL, divider=0, direction=up.
- All state updates on posedge sclk only. No key signal is used as a clock.
- Latency: a pulse sampled at edge N yields new word(s) and upd=1 after edge N; upd is 0 on the next cycle unless another change occurs.
- States: MANUAL, SWEEP_UP, SWEEP_DN.
- MANUAL:
  - key_f_pls: fc_word += F_STEP. If the result would exceed F_MAX, fc_word wraps to F_MIN.
  - key_m_pls: enter SWEEP_UP with divider=0 and sweep_on=1 next cycle. fc_word is unchanged and upd is not asserted.
- SWEEP_UP/SWEEP_DN:
  - Divider counts 0..SWEEP_DIV-1; a tick occurs when the divider is at SWEEP_DIV-1, and the divider then returns to 0.
  - SWEEP_UP tick: fc_word += F_STEP. If fc_word+F_STEP ≥ F_MAX, load F_MAX and go to SWEEP_DN.
  - SWEEP_DN tick: fc_word -= F_STEP. If fc_word−F_STEP ≤ F_MIN, load F_MIN and go to SWEEP_UP.
  - Each tick asserts upd.
  - key_f_pls is ignored.
  - key_m_pls returns to MANUAL and holds the current fc_word. sweep_on=0 next cycle. A tick in the same cycle is discarded.
- Phase, in any state: key_p_pls sets pc_word += P_STEP modulo 2^30 (natural 30-bit wrap) and toggles led0.
- Simultaneous events:
  - key_f with key_p: both words update in the same cycle with a single upd.
  - Sweep tick with key_p: both applied, single upd.
  - key_m with key_f in MANUAL: the mode change wins and key_f is dropped.
- Width rules: all fc arithmetic uses 31-bit intermediates to detect overflow. Parameters must satisfy F_MIN < F_MAX < 2^30 and F_STEP ≤ F_MAX−F_MIN.
- Reset mid-sweep immediately forces the reset values listed above. The divider is cleared.

Test Plan:
- Reset then 3 key_f_pls, spaced 5 cycles apart → fc_word 1074→1076→1078→1080. upd is high exactly 1 cycle after each pulse; pc_word stays 0.
- F_MAX=1080, fc_word=1078: key_f_pls → 1080; next key_f_pls → 430 (wrap to F_MIN).
- key_p_pls ×2 → pc_word 2 then 4, led0 1→0→1. Preload pc_word=2^30−1, then key_p_pls → pc_word=1.
- SWEEP_DIV=4, F_MIN=430, F_MAX=436, start at 430: key_m_pls → ticks every 4 cycles give 432, 434, 436, 434, 432, 430, 432. sweep_on=1 throughout; key_f_pls during the sweep has no effect.
- Same cycle key_f_pls + key_p_pls in MANUAL → fc_word +2, pc_word +2, a single 1-cycle upd. Repeat in SWEEP with key_p_pls on a tick cycle → both updated, single upd.
- Assert rst_n=0 mid-sweep at fc_word=434 → outputs immediately return to FW_INIT/0/0/0/1 asynchronously. After release, state is MANUAL with no upd.
